// File: rtl/lut_share_arbiter.sv
// Two-requester round-robin arbiter in front of one fixed-latency TIE lookup table.
// In-flight requests carry a one-bit requester id down a tag pipeline, which routes each returned word.

module lut_share_port #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ret,
    input  logic          acc,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] rdata,
    output logic          vld,
    output logic [15:0]   cnt
);
    localparam logic [DW-1:0] RST_WORD = DW'(32'hDEADBEEF);

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= RST_WORD;
            vld   <= 1'b0;
            cnt   <= '0;
        end else begin
            vld <= ret;
            if (ret)
                rdata <= data;
            // Saturate rather than wrap so long runs never read back as few grants.
            if (acc && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
    end
endmodule

module lut_share_arbiter #(
    parameter int LAT = 1,  // table read latency, 1..4
    parameter int AW  = 8,
    parameter int DW  = 32
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic [AW-1:0] TIE_lut0_Out,
    input  logic          TIE_lut0_Out_Req,
    output logic [DW-1:0] TIE_lut0_In,
    output logic          TIE_lut0_Rdy,
    output logic          TIE_lut0_Vld,
    input  logic [AW-1:0] TIE_lut1_Out,
    input  logic          TIE_lut1_Out_Req,
    output logic [DW-1:0] TIE_lut1_In,
    output logic          TIE_lut1_Rdy,
    output logic          TIE_lut1_Vld,
    output logic [AW-1:0] LUT_Addr,
    output logic          LUT_Req,
    input  logic [DW-1:0] LUT_Data,
    input  logic          LUT_Rdy,
    output logic [15:0]   Grant0_Cnt,
    output logic [15:0]   Grant1_Cnt
);
    logic                 rr;
    logic [1:0]           req, rdy, acc, ret;
    logic [1:0][AW-1:0]   addr;
    logic [LAT-1:0]       vld_pipe;
    logic [LAT-1:0]       id_pipe;
    logic [1:0][DW-1:0]   rdata;
    logic [1:0]           vld;
    logic [1:0][15:0]     cnt;

    assign req  = {TIE_lut1_Out_Req, TIE_lut0_Out_Req};
    assign addr = {TIE_lut1_Out, TIE_lut0_Out};

    // Ready ignores the port's own request, so only the peer's request can block it.
    assign rdy[0] = LUT_Rdy & ~Reset & (~req[1] | ~rr);
    assign rdy[1] = LUT_Rdy & ~Reset & (~req[0] |  rr);
    assign acc    = req & rdy;

    assign TIE_lut0_Rdy = rdy[0];
    assign TIE_lut1_Rdy = rdy[1];
    assign LUT_Req      = |acc;

    always_comb begin
        LUT_Addr = '0;
        if (acc[0])
            LUT_Addr = addr[0];
        else if (acc[1])
            LUT_Addr = addr[1];
    end

    always_ff @(posedge CLK) begin
        if (Reset)
            rr <= 1'b0;
        else if (acc[0])
            rr <= 1'b1;
        else if (acc[1])
            rr <= 1'b0;
    end

    // Tag pipeline: the last stage lines up with the table's data beat.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= LUT_Req;
            id_pipe[0]  <= acc[1];
            for (int s = 1; s < LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_port
        assign ret[i] = vld_pipe[LAT-1] & (id_pipe[LAT-1] == 1'(i));

        lut_share_port #(.DW(DW)) u_port (
            .clk   (CLK),
            .reset (Reset),
            .ret   (ret[i]),
            .acc   (acc[i]),
            .data  (LUT_Data),
            .rdata (rdata[i]),
            .vld   (vld[i]),
            .cnt   (cnt[i])
        );
    end

    assign TIE_lut0_In  = rdata[0];
    assign TIE_lut1_In  = rdata[1];
    assign TIE_lut0_Vld = vld[0];
    assign TIE_lut1_Vld = vld[1];
    assign Grant0_Cnt   = cnt[0];
    assign Grant1_Cnt   = cnt[1];
endmodule

// File: tb/tb_lut_share_arbiter.sv
// Scoreboard bench: instance 0 runs LAT=1, instance 1 runs LAT=3, each behind a small table model.

module tb_lut_share_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2], q0[2], q1[2], lrdy[2];
    logic [7:0]  a0[2], a1[2], laddr[2];
    logic [31:0] in0[2], in1[2], ldata[2];
    logic        rdy0[2], rdy1[2], v0[2], v1[2], lreq[2];
    logic [15:0] g0[2], g1[2];

    lut_share_arbiter #(.LAT(1), .AW(8), .DW(32)) u_lat1 (
        .CLK(clk), .Reset(rst[0]),
        .TIE_lut0_Out(a0[0]), .TIE_lut0_Out_Req(q0[0]), .TIE_lut0_In(in0[0]),
        .TIE_lut0_Rdy(rdy0[0]), .TIE_lut0_Vld(v0[0]),
        .TIE_lut1_Out(a1[0]), .TIE_lut1_Out_Req(q1[0]), .TIE_lut1_In(in1[0]),
        .TIE_lut1_Rdy(rdy1[0]), .TIE_lut1_Vld(v1[0]),
        .LUT_Addr(laddr[0]), .LUT_Req(lreq[0]), .LUT_Data(ldata[0]), .LUT_Rdy(lrdy[0]),
        .Grant0_Cnt(g0[0]), .Grant1_Cnt(g1[0])
    );

    lut_share_arbiter #(.LAT(3), .AW(8), .DW(32)) u_lat3 (
        .CLK(clk), .Reset(rst[1]),
        .TIE_lut0_Out(a0[1]), .TIE_lut0_Out_Req(q0[1]), .TIE_lut0_In(in0[1]),
        .TIE_lut0_Rdy(rdy0[1]), .TIE_lut0_Vld(v0[1]),
        .TIE_lut1_Out(a1[1]), .TIE_lut1_Out_Req(q1[1]), .TIE_lut1_In(in1[1]),
        .TIE_lut1_Rdy(rdy1[1]), .TIE_lut1_Vld(v1[1]),
        .LUT_Addr(laddr[1]), .LUT_Req(lreq[1]), .LUT_Data(ldata[1]), .LUT_Rdy(lrdy[1]),
        .Grant0_Cnt(g0[1]), .Grant1_Cnt(g1[1])
    );

    function automatic logic [31:0] tbl(input logic [7:0] a);
        case (a)
            8'h00:   tbl = 32'hFACEF00D;
            8'h11:   tbl = 32'hCAFEBABE;
            default: tbl = {4{a}};
        endcase
    endfunction

    // Table models: data appears LAT cycles after the request strobe, filler otherwise.
    logic       pv0 = 1'b0;
    logic [7:0] pa0 = 8'h0;
    logic [2:0] pv1 = 3'b0;
    logic [2:0][7:0] pa1 = '0;
    always @(posedge clk) begin
        pv0 <= lreq[0];
        pa0 <= laddr[0];
        pv1 <= {pv1[1:0], lreq[1]};
        pa1 <= {pa1[1:0], laddr[1]};
    end
    always_comb begin
        ldata[0] = pv0    ? tbl(pa0)    : 32'h0BAD0BAD;
        ldata[1] = pv1[2] ? tbl(pa1[2]) : 32'h0BAD0BAD;
    end

    typedef struct { int port; logic [31:0] data; } exp_t;
    exp_t sb0[$], sb1[$];
    int checks = 0, errors = 0;
    int vcnt[2] = '{0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int p, input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic mon(input int k, input int p, input logic [31:0] d);
        exp_t e;
        bit   empty;
        vcnt[k]++;
        empty = (k == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
        if (empty) begin
            checks++;
            errors++;
            $display("FAIL unexpected_vld: inst %0d port %0d got %h expected no response", k, p, d);
        end else begin
            e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("resp_port_i%0d", k), p, e.port);
            chk($sformatf("resp_data_i%0d", k), d, e.data);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (v0[k] === 1'b1) mon(k, 0, in0[k]);
            if (v1[k] === 1'b1) mon(k, 1, in1[k]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int k);
        rst[k] = 1'b1;
        q0[k]  = 1'b0;
        q1[k]  = 1'b0;
        tick();
        tick();
        rst[k] = 1'b0;
    endtask

    initial begin
        int t;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; q0[k] = 1'b0; q1[k] = 1'b0; lrdy[k] = 1'b1;
            a0[k] = 8'h0;  a1[k] = 8'h0;
        end

        // Reset state; a request during reset must not get through
        tick();
        q0[0] = 1'b1;
        #1;
        chk("rst_rdy0", rdy0[0], 1'b0);
        chk("rst_lreq", lreq[0], 1'b0);
        tick();
        chk("rst_in0", in0[0], 32'hDEADBEEF);
        chk("rst_in1", in1[0], 32'hDEADBEEF);
        chk("rst_vld0", v0[0], 1'b0);
        chk("rst_cnt0", g0[0], 16'h0);
        chk("rst_in0_l3", in0[1], 32'hDEADBEEF);
        q0[0] = 1'b0;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Single requester, LAT=1
        a0[0] = 8'h33; q0[0] = 1'b1;
        #1;
        chk("single_rdy0", rdy0[0], 1'b1);
        chk("single_lreq", lreq[0], 1'b1);
        chk("single_addr", laddr[0], 8'h33);
        push(0, 0, 32'h33333333);
        tick();
        q0[0] = 1'b0;
        #1;
        chk("single_idle", lreq[0], 1'b0);
        tick();
        chk("single_in0", in0[0], 32'h33333333);
        chk("single_vld0", v0[0], 1'b1);
        chk("single_in1", in1[0], 32'hDEADBEEF);

        // Contention, LAT=1: grants alternate starting at port 0
        do_reset(0);
        a0[0] = 8'h11; a1[0] = 8'h22; q0[0] = 1'b1; q1[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i % 2 == 0) begin
                chk("cont_rdy0", rdy0[0], 1'b1);
                chk("cont_rdy1", rdy1[0], 1'b0);
                chk("cont_addr", laddr[0], 8'h11);
                push(0, 0, 32'hCAFEBABE);
            end else begin
                chk("cont_rdy0", rdy0[0], 1'b0);
                chk("cont_rdy1", rdy1[0], 1'b1);
                chk("cont_addr", laddr[0], 8'h22);
                push(0, 1, 32'h22222222);
            end
            tick();
        end
        q0[0] = 1'b0; q1[0] = 1'b0;
        #1;
        chk("cont_cnt0", g0[0], 16'd2);
        chk("cont_cnt1", g1[0], 16'd2);
        tick(); tick();

        // LAT=3 pipelining, alternating ports on consecutive cycles
        a0[1] = 8'h00; q0[1] = 1'b1;
        #1;
        chk("p3_rdy0_a", rdy0[1], 1'b1);
        push(1, 0, 32'hFACEF00D);
        tick();
        q0[1] = 1'b0; a1[1] = 8'h77; q1[1] = 1'b1;
        #1;
        chk("p3_rdy1_b", rdy1[1], 1'b1);
        push(1, 1, 32'h77777777);
        tick();
        q1[1] = 1'b0; a0[1] = 8'hBB; q0[1] = 1'b1;
        #1;
        chk("p3_rdy0_c", rdy0[1], 1'b1);
        push(1, 0, 32'hBBBBBBBB);
        tick();
        q0[1] = 1'b0;
        chk("p3_not_early", v0[1], 1'b0);
        tick();
        chk("p3_vld_a", v0[1], 1'b1);
        chk("p3_in_a", in0[1], 32'hFACEF00D);
        tick();
        chk("p3_vld_b", v1[1], 1'b1);
        chk("p3_in_b", in1[1], 32'h77777777);
        tick();
        chk("p3_vld_c", v0[1], 1'b1);
        chk("p3_in_c", in0[1], 32'hBBBBBBBB);
        chk("p3_cnt0", g0[1], 16'd2);
        chk("p3_cnt1", g1[1], 16'd1);

        // Backpressure: nothing accepted, pointer stays on port 0
        do_reset(0);
        lrdy[0] = 1'b0; a0[0] = 8'h44; q0[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rdy0", rdy0[0], 1'b0);
            chk("bp_lreq", lreq[0], 1'b0);
            tick();
        end
        lrdy[0] = 1'b1; a1[0] = 8'h55; q1[0] = 1'b1;
        #1;
        chk("bp_rel_rdy0", rdy0[0], 1'b1);
        chk("bp_rel_rdy1", rdy1[0], 1'b0);
        chk("bp_rel_addr", laddr[0], 8'h44);
        push(0, 0, 32'h44444444);
        tick();
        q0[0] = 1'b0;
        #1;
        chk("bp_next_rdy1", rdy1[0], 1'b1);
        chk("bp_next_addr", laddr[0], 8'h55);
        push(0, 1, 32'h55555555);
        tick();
        q1[0] = 1'b0;
        tick(); tick();

        // Reset mid-flight, LAT=3: the late table beat must be dropped
        t = vcnt[1];
        a0[1] = 8'h33; q0[1] = 1'b1;
        #1;
        chk("mid_lreq", lreq[1], 1'b1);
        tick();
        q0[1] = 1'b0; rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        repeat (6) tick();
        chk("mid_no_vld", vcnt[1], t);
        chk("mid_in0", in0[1], 32'hDEADBEEF);
        chk("mid_in1", in1[1], 32'hDEADBEEF);
        chk("mid_cnt0", g0[1], 16'd0);
        chk("mid_cnt1", g1[1], 16'd0);

        // Counter saturation
        do_reset(0);
        a0[0] = 8'h5A; q0[0] = 1'b1;
        for (int i = 1; i <= 65540; i++) begin
            push(0, 0, 32'h5A5A5A5A);
            tick();
            if (i == 65534) chk("sat_fffe", g0[0], 16'hFFFE);
            if (i == 65535) chk("sat_ffff", g0[0], 16'hFFFF);
        end
        q0[0] = 1'b0;
        #1;
        chk("sat_hold", g0[0], 16'hFFFF);
        chk("sat_cnt1", g1[0], 16'h0);
        tick(); tick(); tick();

        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lut_share_arbiter.md
# lut_share_arbiter

Shares one TIE lookup table device between two Xtensa TIE lookup requester ports. Round-robin arbitration selects at most one request per cycle, forwards it to the table, and tracks in-flight requests in a tag pipeline matched to the table's fixed latency. Each returned word is routed back to the requester that issued it. The block sits in the XTSC cosim Verilog sources, between the core-side lookup ports and a single table model.

## Interface
- `LAT`, default 1: table read latency in cycles, from `LUT_Req` to valid `LUT_Data`; legal range 1..4.
- `AW`, default 8: lookup address width.
- `DW`, default 32: lookup data width.
- `CLK`  in  1  clock; all state updates on posedge.
- `Reset`  in  1  synchronous, active-high reset.
- `TIE_lut0_Out`  in  AW  requester 0 lookup address.
- `TIE_lut0_Out_Req`  in  1  requester 0 request; held until accepted.
- `TIE_lut0_In`  out  DW  requester 0 returned data; holds its last value.
- `TIE_lut0_Rdy`  out  1  requester 0 may be accepted this cycle.
- `TIE_lut0_Vld`  out  1  one-cycle pulse: `TIE_lut0_In` was updated this cycle.
- `TIE_lut1_Out`, `TIE_lut1_Out_Req`, `TIE_lut1_In`, `TIE_lut1_Rdy`, `TIE_lut1_Vld`: same as the port-0 signals, for requester 1.
- `LUT_Addr`  out  AW  address to the shared table.
- `LUT_Req`  out  1  table request strobe.
- `LUT_Data`  in  DW  table read data, valid `LAT` cycles after `LUT_Req`.
- `LUT_Rdy`  in  1  table can accept a request this cycle.
- `Grant0_Cnt`, `Grant1_Cnt`  out  16  saturating accept counters, per requester.

## Operation
- **Ready generation** (combinational). Rdy does not depend on the requester's own Req.
  - `TIE_lut0_Rdy = LUT_Rdy & ~Reset & (~TIE_lut1_Out_Req | rr==0)`
  - `TIE_lut1_Rdy = LUT_Rdy & ~Reset & (~TIE_lut0_Out_Req | rr==1)`
- **Accept.** `acc_i = TIE_luti_Out_Req & TIE_luti_Rdy`. At most one accept per cycle by construction.
- **Issue.**
  - `LUT_Req = acc0 | acc1` (combinational).
  - `LUT_Addr` = accepted requester's `Out`; all-zeros when no accept.
- **Round-robin pointer `rr`.**
  - After `acc0`, rr←1; after `acc1`, rr←0.
  - No accept: rr unchanged.
  - Reset value: 0 (requester 0 wins the first contention).
- **Tag pipeline.** `LAT` stages of {valid, id}.
  - Stage 0 loads {`LUT_Req`, `acc1`}; stages shift every cycle.
  - When the last stage is valid: capture `LUT_Data` into `TIE_lut<id>_In` and pulse `TIE_lut<id>_Vld` for one cycle.
- **Counters.** `Grant*_Cnt` increment on each accept and saturate at 16'hFFFF.
- **Non-accepted requester.** No state change; it keeps Req high until accepted.

## Timing
- **Reset values** (applied on the posedge with `Reset`=1):
  - `TIE_lut*_In` = 32'hDEADBEEF
  - `TIE_lut*_Vld` = 0
  - all tag stages invalid
  - rr = 0
  - counters = 0
- **During `Reset`:** Rdy = 0 and `LUT_Req` = 0.
- **Accept-to-data latency:**
  - Accept at edge N → `TIE_lut_In` updated and `Vld` = 1 after edge N+`LAT`.
  - With `LAT`=1: data is visible the cycle after the accept.
- **Throughput:** one accept per cycle total; back-to-back accepts fully pipelined.
- **Contention:** both requests held continuously with `LUT_Rdy`=1 → grants alternate 0,1,0,1…
- **`LUT_Rdy`=0:** no Rdy asserted, no accept, rr unchanged. In-flight tags keep shifting and responses still return.
- **Reset mid-operation:** all in-flight tags are discarded. A `LUT_Data` arriving after reset deasserts is ignored. `In` holds 32'hDEADBEEF until a new response.
- **Response collisions:** impossible; only one accept per cycle means only one tag retires per cycle.
- **Counter saturation:** at 16'hFFFF, further accepts leave the counter unchanged.

## Test plan
- **Single requester, LAT=1.** Bench table maps 0x33→0x33333333. Req0 with addr 0x33 → `TIE_lut0_Rdy`=1, `LUT_Req` pulse with `LUT_Addr`=0x33; next cycle `TIE_lut0_In`=0x33333333, `Vld0`=1; port 1 `In` stays 0xDEADBEEF.
- **Contention, LAT=1.** Both requesters hold Req (addr0=0x11, addr1=0x22) for 4 cycles. Bench table maps 0x11→0xCAFEBABE and 0x22→0x22222222. → accepts ordered 0,1,0,1; `Grant0_Cnt`=`Grant1_Cnt`=2; each port receives its own value.
- **LAT=3 pipelining.** Accept addresses 0x00, 0x77, 0xBB on consecutive cycles, alternating ports. Bench table maps 0x00→0xFACEF00D, 0x77→0x77777777, 0xBB→0xBBBBBBBB. → responses arrive 3 cycles after each accept, in issue order, each on the correct port.
- **Backpressure.** Hold `LUT_Rdy`=0 for 5 cycles with Req0 high → no `LUT_Req`, `Rdy0`=0, rr stays 0; accept occurs the first cycle `LUT_Rdy`=1.
- **Reset mid-flight, LAT=3.** Assert `Reset` one cycle after accepting addr 0x33 → no `Vld` pulse; `In`=0xDEADBEEF; counters=0.
- **Saturation.** Force 65,540 accepts on port 0 → `Grant0_Cnt`=0xFFFF.
